// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake, STAGES-cycle latency and a persistent {N,Z,V,C}
// flag register updated when a flag-setting op retires.
module alu_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [3:0]       flags_q
);
    localparam int SHW = $clog2(WIDTH);
    // payload = {set_flags, result, N, Z, V, C}
    localparam int PW  = WIDTH + 5;

    logic [WIDTH:0]             add_ext;
    logic [WIDTH:0]             sub_ext;
    logic [WIDTH-1:0]           res_c;
    logic                       v_c;
    logic                       c_c;
    logic [PW-1:0]              pay_c;
    logic [STAGES-1:0]          vld_q;
    logic [STAGES-1:0][PW-1:0]  pay_q;
    logic                       stall;
    logic                       accept;
    logic                       retire;

    assign add_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res_c = '0;
        v_c   = 1'b0;
        c_c   = 1'b0;
        case (cntrl)
            3'b001: res_c = A << B[SHW-1:0];
            3'b010: begin
                res_c = add_ext[WIDTH-1:0];
                c_c   = add_ext[WIDTH];
                v_c   = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b011: begin
                res_c = sub_ext[WIDTH-1:0];
                c_c   = sub_ext[WIDTH];
                v_c   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b100: res_c = A & B;
            3'b101: res_c = A | B;
            3'b110: res_c = A ^ B;
            3'b111: res_c = A >> B[SHW-1:0];
            default: res_c = B;
        endcase
    end

    assign pay_c = {set_flags, res_c, res_c[WIDTH-1], ~|res_c, v_c, c_c};

    assign out_valid = vld_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    // Whole pipe freezes on stall; bubbles move only the valid bits, payload follows real ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            pay_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            if (retire && pay_q[STAGES-1][PW-1])
                flags_q <= pay_q[STAGES-1][3:0];
            if (!stall) begin
                vld_q[0] <= accept;
                if (accept)
                    pay_q[0] <= pay_c;
                for (int i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1])
                        pay_q[i] <= pay_q[i-1];
                end
            end
        end
    end

    assign result    = pay_q[STAGES-1][WIDTH+3:4];
    assign negative  = pay_q[STAGES-1][3];
    assign zero      = pay_q[STAGES-1][2];
    assign overflow  = pay_q[STAGES-1][1];
    assign carry_out = pay_q[STAGES-1][0];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed checks on a 64-bit/2-stage instance and a randomized sweep of an 8-bit/1-stage
// instance against an integer-arithmetic reference model.
module tb_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst64_n, iv64, ir64, sf64, ov64, or64, n64, z64, v64, c64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  op64;
    logic [3:0]  fq64;

    logic        rst8_n, iv8, ir8, sf8, ov8, or8, n8, z8, v8, c8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;
    logic [3:0]  fq8;

    alu_pipe #(.WIDTH(64), .STAGES(2)) dut64 (
        .clk(clk), .reset_n(rst64_n), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
        .cntrl(op64), .set_flags(sf64), .out_valid(ov64), .out_ready(or64), .result(res64),
        .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64), .flags_q(fq64)
    );

    alu_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .cntrl(op8), .set_flags(sf8), .out_valid(ov8), .out_ready(or8), .result(res8),
        .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8), .flags_q(fq8)
    );

    task automatic drive64(input logic v, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic sf);
        iv64 = v;
        op64 = op;
        a64  = a;
        b64  = b;
        sf64 = sf;
    endtask

    // Reference for the 8-bit instance, built on int arithmetic; returns {result, N, Z, V, C}.
    function automatic logic [11:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        int s;
        int sv;
        logic [7:0] r;
        logic v;
        logic c;
        r = 8'd0;
        v = 1'b0;
        c = 1'b0;
        s = 0;
        sv = 0;
        case (op)
            3'd0: r = b;
            3'd1: r = a << b[2:0];
            3'd2: begin
                s  = int'(a) + int'(b);
                sv = int'($signed(a)) + int'($signed(b));
                r  = s[7:0];
                c  = (s > 255);
                v  = (sv > 127) || (sv < -128);
            end
            3'd3: begin
                s  = int'(a) - int'(b);
                sv = int'($signed(a)) - int'($signed(b));
                r  = s[7:0];
                c  = (a >= b);
                v  = (sv > 127) || (sv < -128);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = a >> b[2:0];
        endcase
        return {r, r[7], (r == 8'd0), v, c};
    endfunction

    task automatic test_reset();
        rst64_n = 1'b0;
        rst8_n  = 1'b0;
        drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
        or64 = 1'b1;
        iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; op8 = 3'd0; sf8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL reset_out_valid64 got=%b exp=0", ov64); end
        checks++; if (res64 !== 64'd0) begin failures++; $display("FAIL reset_result64 got=%h exp=0", res64); end
        checks++; if ({n64, z64, v64, c64} !== 4'b0000) begin failures++; $display("FAIL reset_nzvc64 got=%b exp=0000", {n64, z64, v64, c64}); end
        checks++; if (fq64 !== 4'b0000) begin failures++; $display("FAIL reset_flags_q64 got=%b exp=0000", fq64); end
        checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL reset_in_ready64 got=%b exp=1", ir64); end
        checks++; if ({ov8, res8, fq8} !== 13'd0) begin failures++; $display("FAIL reset_dut8 got=%h exp=0", {ov8, res8, fq8}); end
        rst64_n = 1'b1;
        rst8_n  = 1'b1;
    endtask

    task automatic test_add_flags();
        @(negedge clk);
        or64 = 1'b1;
        drive64(1'b1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL add_latency_early got=%b exp=0", ov64); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", ov64); end
        checks++; if (res64 !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_result got=%h exp=8000000000000000", res64); end
        checks++; if ({n64, z64, v64, c64} !== 4'b1010) begin failures++; $display("FAIL add_nzvc got=%b exp=1010", {n64, z64, v64, c64}); end
        checks++; if (fq64 !== 4'b0000) begin failures++; $display("FAIL add_flags_before_retire got=%b exp=0000", fq64); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (fq64 !== 4'b1010) begin failures++; $display("FAIL add_flags_q got=%b exp=1010", fq64); end
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL add_retired got=%b exp=0", ov64); end
    endtask

    task automatic test_sub_noflags();
        @(negedge clk);
        drive64(1'b1, 3'b011, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b1) begin failures++; $display("FAIL sub_out_valid got=%b exp=1", ov64); end
        checks++; if (res64 !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sub_result got=%h exp=7fffffffffffffff", res64); end
        checks++; if ({n64, z64, v64, c64} !== 4'b0011) begin failures++; $display("FAIL sub_nzvc got=%b exp=0011", {n64, z64, v64, c64}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (fq64 !== 4'b1010) begin failures++; $display("FAIL sub_flags_unchanged got=%b exp=1010", fq64); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [63:0] as  [4];
        logic [63:0] bs  [4];
        logic        sfs [4];
        logic [63:0] er  [4];
        logic [3:0]  ef  [4];
        ops = '{3'b010, 3'b011, 3'b001, 3'b111};
        as  = '{64'd1, 64'd5, 64'd1, 64'h8000_0000_0000_0000};
        bs  = '{64'd1, 64'd5, 64'd63, 64'd63};
        sfs = '{1'b0, 1'b1, 1'b0, 1'b0};
        er  = '{64'd2, 64'd0, 64'h8000_0000_0000_0000, 64'd1};
        ef  = '{4'b0000, 4'b0101, 4'b1000, 4'b0000};
        or64 = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                checks++; if (ov64 !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", cyc - 2, ov64); end
                checks++; if (res64 !== er[cyc-2]) begin failures++; $display("FAIL b2b_result[%0d] got=%h exp=%h", cyc - 2, res64, er[cyc-2]); end
                checks++; if ({n64, z64, v64, c64} !== ef[cyc-2]) begin failures++; $display("FAIL b2b_nzvc[%0d] got=%b exp=%b", cyc - 2, {n64, z64, v64, c64}, ef[cyc-2]); end
            end
            if (cyc < 4) drive64(1'b1, ops[cyc], as[cyc], bs[cyc], sfs[cyc]);
            else         drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", ov64); end
        checks++; if (fq64 !== 4'b0101) begin failures++; $display("FAIL b2b_flags_q got=%b exp=0101", fq64); end
    endtask

    task automatic test_logic_ops();
        logic [2:0]  ops [5];
        logic [63:0] as  [5];
        logic [63:0] bs  [5];
        logic [63:0] er  [5];
        logic [3:0]  ef  [5];
        ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b001};
        as  = '{64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000,
                64'hFFFF_0000_FFFF_0000, 64'd3};
        bs  = '{64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F,
                64'h0F0F_0F0F_0F0F_0F0F, 64'd65};
        er  = '{64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000, 64'hFFFF_0F0F_FFFF_0F0F,
                64'hF0F0_0F0F_F0F0_0F0F, 64'd6};
        ef  = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        or64 = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                checks++; if (ov64 !== 1'b1) begin failures++; $display("FAIL logic_valid[%0d] got=%b exp=1", cyc - 2, ov64); end
                checks++; if (res64 !== er[cyc-2]) begin failures++; $display("FAIL logic_result[%0d] got=%h exp=%h", cyc - 2, res64, er[cyc-2]); end
                checks++; if ({n64, z64, v64, c64} !== ef[cyc-2]) begin failures++; $display("FAIL logic_nzvc[%0d] got=%b exp=%b", cyc - 2, {n64, z64, v64, c64}, ef[cyc-2]); end
            end
            if (cyc < 5) drive64(1'b1, ops[cyc], as[cyc], bs[cyc], 1'b0);
            else         drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
            @(posedge clk);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        or64 = 1'b0;
        drive64(1'b1, 3'b010, 64'd10, 64'd20, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL bp_early_valid got=%b exp=0", ov64); end
        drive64(1'b1, 3'b110, 64'hFF, 64'h0F, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive64(1'b1, 3'b011, 64'd3, 64'd5, 1'b1);
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++; if (ir64 !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", s, ir64); end
            checks++; if (ov64 !== 1'b1) begin failures++; $display("FAIL bp_valid_held[%0d] got=%b exp=1", s, ov64); end
            checks++; if (res64 !== 64'd30) begin failures++; $display("FAIL bp_result_held[%0d] got=%h exp=1e", s, res64); end
            checks++; if (fq64 !== 4'b0101) begin failures++; $display("FAIL bp_flags_held[%0d] got=%b exp=0101", s, fq64); end
            @(posedge clk);
            @(negedge clk);
        end
        or64 = 1'b1;
        #1;
        checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ir64); end
        checks++; if (res64 !== 64'd30) begin failures++; $display("FAIL bp_first_result got=%h exp=1e", res64); end
        @(posedge clk);
        @(negedge clk);
        drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
        checks++; if (ov64 !== 1'b1 || res64 !== 64'hF0) begin failures++; $display("FAIL bp_second_result got=%b/%h exp=1/f0", ov64, res64); end
        checks++; if ({n64, z64, v64, c64} !== 4'b0000) begin failures++; $display("FAIL bp_second_nzvc got=%b exp=0000", {n64, z64, v64, c64}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b1 || res64 !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL bp_third_result got=%b/%h exp=1/fffffffffffffffe", ov64, res64); end
        checks++; if ({n64, z64, v64, c64} !== 4'b1000) begin failures++; $display("FAIL bp_third_nzvc got=%b exp=1000", {n64, z64, v64, c64}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL bp_no_duplicate got=%b exp=0", ov64); end
        checks++; if (fq64 !== 4'b1000) begin failures++; $display("FAIL bp_flags_q got=%b exp=1000", fq64); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        or64 = 1'b1;
        drive64(1'b1, 3'b010, 64'd1, 64'd2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive64(1'b1, 3'b000, 64'd0, 64'h55, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
        or64 = 1'b0;
        #1;
        checks++; if (ov64 !== 1'b1 || res64 !== 64'd3) begin failures++; $display("FAIL rst_pre_state got=%b/%h exp=1/3", ov64, res64); end
        #1 rst64_n = 1'b0;
        #1;
        checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", ov64); end
        checks++; if (res64 !== 64'd0) begin failures++; $display("FAIL rst_result got=%h exp=0", res64); end
        checks++; if ({n64, z64, v64, c64} !== 4'b0000) begin failures++; $display("FAIL rst_nzvc got=%b exp=0000", {n64, z64, v64, c64}); end
        checks++; if (fq64 !== 4'b0000) begin failures++; $display("FAIL rst_flags_q got=%b exp=0000", fq64); end
        checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", ir64); end
        @(posedge clk);
        #2 rst64_n = 1'b1;
        or64 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (ov64 !== 1'b0) begin failures++; $display("FAIL rst_stale_valid[%0d] got=%b exp=0", k, ov64); end
        end
        @(negedge clk);
        drive64(1'b1, 3'b000, 64'hFF, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive64(1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checks++; if (ov64 !== 1'b1 || {n64, z64, v64, c64} !== 4'b0100) begin failures++; $display("FAIL rst_post_op got=%b/%b exp=1/0100", ov64, {n64, z64, v64, c64}); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (fq64 !== 4'b0100) begin failures++; $display("FAIL rst_post_flags got=%b exp=0100", fq64); end
    endtask

    task automatic test_random8();
        logic        ev = 1'b0;
        logic [11:0] ep = 12'd0;
        logic        esf = 1'b0;
        logic [3:0]  efq = 4'b0000;
        logic        er;
        logic        acc;
        logic [11:0] m;
        int          acc_n = 0;
        int          cyc = 0;
        while (acc_n < 1000 && cyc < 20000) begin
            @(negedge clk);
            checks++; if (ov8 !== ev) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, ov8, ev); end
            if (ev) begin
                checks++; if ({res8, n8, z8, v8, c8} !== ep) begin failures++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, {res8, n8, z8, v8, c8}, ep); end
            end
            checks++; if (fq8 !== efq) begin failures++; $display("FAIL rnd_flags_q cyc=%0d got=%b exp=%b", cyc, fq8, efq); end
            iv8 = ($urandom_range(0, 3) != 0);
            or8 = ($urandom_range(0, 3) != 0);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            op8 = 3'($urandom_range(0, 7));
            sf8 = 1'($urandom_range(0, 1));
            er  = !(ev && !or8);
            acc = iv8 && er;
            m   = model8(a8, b8, op8);
            #1;
            checks++; if (ir8 !== er) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, ir8, er); end
            @(posedge clk);
            if (ev && or8 && esf) efq = ep[3:0];
            if (acc) begin
                ev  = 1'b1;
                ep  = m;
                esf = sf8;
                acc_n++;
            end else if (!(ev && !or8)) begin
                ev = 1'b0;
            end
            cyc++;
        end
        iv8 = 1'b0;
        checks++; if (acc_n != 1000) begin failures++; $display("FAIL rnd_timeout accepted=%0d exp=1000", acc_n); end
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_sub_noflags();
        test_back_to_back();
        test_logic_ops();
        test_backpressure();
        test_reset_midstream();
        test_random8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
